layer_sequencer: RTL
====================

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, giving the buffer address width and the length-field width.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request one layer pass; sampled only in IDLE.
REQ-005 SHALL have port len  input  ADDR_W  item count for the pass (0..2^ADDR_W-1); latched on accepted start.
REQ-006 SHALL have port abort  input  1  cancel the pass in progress (present only per REQ-024).
REQ-007 SHALL have port wr_en  output  1  buffer write strobe, one item per cycle.
REQ-008 SHALL have port rd_en  output  1  buffer read strobe, one item per cycle.
REQ-009 SHALL have port addr  output  ADDR_W  buffer address for the current wr_en/rd_en.
REQ-010 SHALL have port acc_clr  output  1  one-cycle accumulator clear at pass start.
REQ-011 SHALL have port acc_en  output  1  accumulate strobe, rd_en delayed one cycle (1-cycle read latency).
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse on pass completion.

Function
REQ-014 SHALL implement states IDLE, LOAD, READ, DRAIN, DONE; all outputs registered.
REQ-015 IDLE: start=1 with len=N>0 SHALL latch N, set addr=0 and go to LOAD; the first LOAD cycle SHALL carry wr_en=1, addr=0, acc_clr=1.
REQ-016 IDLE: start=1 with len=0 SHALL stay IDLE and pulse done in the next cycle, with no other strobes.
REQ-017 LOAD: wr_en=1 for exactly N cycles, addr 0..N-1 incrementing by 1; after addr=N-1 go to READ with addr=0.
REQ-018 READ: rd_en=1 for exactly N cycles, addr 0..N-1; after addr=N-1 go to DRAIN.
REQ-019 acc_en SHALL be high exactly in the N cycles following each rd_en cycle (last one during DRAIN).
REQ-020 DRAIN: one cycle, then DONE; DONE: done=1 for one cycle, then IDLE.
REQ-021 Timeline, cycle 1 = first cycle after the start-sampling edge: wr_en cycles 1..N, rd_en cycles N+1..2N, acc_en cycles N+2..2N+1, done cycle 2N+2, busy cycles 1..2N+2.
REQ-022 start and len changes while busy SHALL be ignored; a start sampled in the DONE cycle SHALL be ignored; back-to-back passes need start high in IDLE.
REQ-023 addr SHALL hold its last value outside LOAD/READ; N=2^ADDR_W-1 SHALL run with no address wrap.

Configuration
REQ-024 With macro LAYER_SEQ_ABORT_EN defined, port abort SHALL exist: abort=1 sampled while busy (LOAD, READ, DRAIN) SHALL force IDLE next cycle with wr_en, rd_en, acc_en, acc_clr, done all 0 and addr=0; abort in IDLE or DONE SHALL be ignored (the DONE pulse completes); simultaneous start+abort in IDLE SHALL accept start. Without the macro, the abort port and all abort logic SHALL be absent.

Reset
REQ-025 reset_n=0 at a rising edge SHALL set state=IDLE, addr=0, latched len=0, and wr_en, rd_en, acc_clr, acc_en, busy, done all 0, including mid-pass.
REQ-026 The first edge with reset_n=1 SHALL be able to accept start.

Verification
REQ-027 Reset, then start with len=3 -> wr_en cycles 1-3 at addr 0,1,2; rd_en cycles 4-6 at addr 0,1,2; acc_en cycles 5-7; done cycle 8 only; acc_clr cycle 1 only.
REQ-028 start with len=0 -> done high in cycle 1 only, busy, wr_en, rd_en, acc_en never high.
REQ-029 len=15, ADDR_W=4 -> addr reaches 14 in both phases, never 15 or wrap; done at cycle 32.
REQ-030 len=4, start re-asserted and len changed to 9 during LOAD -> pass completes with 4 items, done cycle 10, no second pass.
REQ-031 reset_n low for one edge during READ of a len=5 pass -> all outputs 0 next cycle; new start len=2 then gives done at cycle 6.
REQ-032 LAYER_SEQ_ABORT_EN defined: abort in cycle 5 of a len=6 pass -> all strobes 0 from cycle 6, busy 0, done never pulses.

Source files
------------

// File: rtl/layer_sequencer.sv
// Layer pass sequencer: writes N items into a buffer, reads them back, then drains and pulses done.
// Optional abort port and logic are enabled by defining LAYER_SEQ_ABORT_EN.
module layer_sequencer #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
`ifdef LAYER_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              acc_clr_q, acc_clr_d;
  logic              acc_en_q, acc_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              last_c;

  // Outputs are the registered values of the next-cycle decode below.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      acc_clr_q <= 1'b0;
      acc_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      acc_clr_q <= acc_clr_d;
      acc_en_q  <= acc_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign last_c = (addr_q == (len_q - ADDR_W'(1)));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    acc_clr_d = 1'b0;
    acc_en_d  = rd_en_q;  // one-cycle read latency
    busy_d    = 1'b1;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (len != '0) begin
            len_d     = len;
            addr_d    = '0;
            state_d   = S_LOAD;
            wr_en_d   = 1'b1;
            acc_clr_d = 1'b1;
            busy_d    = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (last_c) begin
          state_d = S_READ;
          addr_d  = '0;
          rd_en_d = 1'b1;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          wr_en_d = 1'b1;
        end
      end
      S_READ: begin
        if (last_c) begin
          state_d = S_DRAIN;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          rd_en_d = 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

`ifdef LAYER_SEQ_ABORT_EN
    // Abort overrides everything while a pass is in flight; the DONE pulse is left to complete.
    if (abort && (state_q == S_LOAD || state_q == S_READ || state_q == S_DRAIN)) begin
      state_d   = S_IDLE;
      addr_d    = '0;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      acc_clr_d = 1'b0;
      acc_en_d  = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
    end
`endif
  end

  assign wr_en   = wr_en_q;
  assign rd_en   = rd_en_q;
  assign addr    = addr_q;
  assign acc_clr = acc_clr_q;
  assign acc_en  = acc_en_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
